// File: rtl/prio_req_arbiter.sv
// rtl/prio_req_arbiter.sv - registered 4-source fixed-priority arbiter with valid/ready offer,
// done-or-timeout release, sticky pending requests and X/Z request rejection.
module prio_req_arbiter #(
   parameter int TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic       grant_valid,
   input  logic       grant_ready,
   output logic [1:0] grant_id,
   output logic [3:0] grant_onehot,
   output logic       busy,
   input  logic       done,
   output logic [3:0] pending,
   output logic       xz_err,
   output logic       timeout_err
);

   typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;

   state_t     state;
   logic [7:0] count;
   logic       req_bad;
   logic [3:0] req_c;
   logic [3:0] pend_nxt;
   logic [1:0] sel_id;

   // A request word with any unknown bit is dropped whole; only the error flag records it.
   always_comb begin
      req_bad  = $isunknown(req);
      req_c    = req_bad ? 4'b0000 : req;
      pend_nxt = pending | req_c;
      if (pend_nxt[3])      sel_id = 2'd3;
      else if (pend_nxt[2]) sel_id = 2'd2;
      else if (pend_nxt[1]) sel_id = 2'd1;
      else                  sel_id = 2'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         count        <= 8'd0;
         pending      <= 4'b0000;
         grant_valid  <= 1'b0;
         grant_id     <= 2'd0;
         grant_onehot <= 4'b0000;
         busy         <= 1'b0;
         xz_err       <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         xz_err      <= req_bad;
         timeout_err <= 1'b0;
         pending     <= pend_nxt;
         case (state)
            IDLE: begin
               if (pend_nxt != 4'b0000) begin
                  pending      <= pend_nxt & ~(4'b0001 << sel_id);
                  grant_id     <= sel_id;
                  grant_onehot <= 4'b0001 << sel_id;
                  grant_valid  <= 1'b1;
                  state        <= OFFER;
               end
            end
            OFFER: begin
               if (grant_ready) begin
                  grant_valid <= 1'b0;
                  busy        <= 1'b1;
                  count       <= 8'd0;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               // done takes precedence over an expiring counter on the same edge
               if (done) begin
                  busy         <= 1'b0;
                  grant_onehot <= 4'b0000;
                  state        <= IDLE;
               end else if (count == 8'(TIMEOUT - 1)) begin
                  timeout_err  <= 1'b1;
                  busy         <= 1'b0;
                  grant_onehot <= 4'b0000;
                  state        <= IDLE;
               end else begin
                  count <= count + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prio_req_arbiter.sv
// tb/tb_prio_req_arbiter.sv - self-checking bench for prio_req_arbiter
module tb_prio_req_arbiter;
   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       rst_n, grant_ready, done;
   logic [3:0] req;
   logic       grant_valid, busy, xz_err, timeout_err;
   logic [1:0] grant_id;
   logic [3:0] grant_onehot, pending;
   logic [13:0] e;
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   prio_req_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .grant_valid(grant_valid), .grant_ready(grant_ready),
      .grant_id(grant_id), .grant_onehot(grant_onehot),
      .busy(busy), .done(done), .pending(pending),
      .xz_err(xz_err), .timeout_err(timeout_err)
   );

   function automatic logic [13:0] obs();
      return {grant_valid, busy, grant_id, grant_onehot, pending, xz_err, timeout_err};
   endfunction

   function automatic logic [13:0] exp_v(logic v, logic b, logic [1:0] id, logic [3:0] oh,
                                         logic [3:0] p, logic x, logic t);
      return {v, b, id, oh, p, x, t};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = 4'b0000; grant_ready = 1'b0; done = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain();
      req = 4'b0000; grant_ready = 1'b1; done = 1'b0;
      step();
      grant_ready = 1'b0; done = 1'b1;
      step();
      done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 4'b0000; grant_ready = 1'b0; done = 1'b0;
      #3;
      n_checks++;
      if (obs() !== 14'd0) begin n_fail++; $display("FAIL reset_state: got %b expected %b", obs(), 14'd0); end
      #10;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (obs() !== 14'd0) begin n_fail++; $display("FAIL idle_no_req[%0d]: got %b expected %b", i, obs(), 14'd0); end
      end
   endtask

   task automatic test_basic();
      req = 4'b0110;
      step();
      e = exp_v(1, 0, 2, 4'b0100, 4'b0010, 0, 0); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL basic_grant2: got %b expected %b", obs(), e); end
      req = 4'b0000; grant_ready = 1'b1;
      step();
      e = exp_v(0, 1, 2, 4'b0100, 4'b0010, 0, 0); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL basic_handshake: got %b expected %b", obs(), e); end
      grant_ready = 1'b0; done = 1'b1;
      step();
      e = exp_v(0, 0, 2, 4'b0000, 4'b0010, 0, 0); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL basic_done: got %b expected %b", obs(), e); end
      done = 1'b0;
      step();
      e = exp_v(1, 0, 1, 4'b0010, 4'b0000, 0, 0); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL basic_next_grant1: got %b expected %b", obs(), e); end
      drain();
   endtask

   task automatic test_all_four();
      int order[$];
      req = 4'b1111; grant_ready = 1'b1; done = 1'b1;
      step();
      req = 4'b0000;
      for (int i = 0; i < 30; i++) begin
         if (grant_valid === 1'b1) order.push_back(int'(grant_id));
         step();
      end
      grant_ready = 1'b0; done = 1'b0;
      n_checks++;
      if (order.size() != 4) begin n_fail++; $display("FAIL all_four_count: got %0d expected 4", order.size()); end
      for (int i = 0; i < 4 && i < order.size(); i++) begin
         n_checks++;
         if (order[i] != 3 - i) begin n_fail++; $display("FAIL all_four_order[%0d]: got %0d expected %0d", i, order[i], 3 - i); end
      end
      step();
      e = exp_v(0, 0, 0, 4'b0000, 4'b0000, 0, 0); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL all_four_final: got %b expected %b", obs(), e); end
   endtask

   task automatic test_xz();
      logic probe;
      logic [3:0] bad;
      probe = 1'bx;
      bad = 4'b10xz;
      if (probe === 1'bx) begin
         req = bad;
         step();
         e = exp_v(0, 0, 0, 4'b0000, 4'b0000, 1, 0); n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL xz_flag: got %b expected %b", obs(), e); end
         req = 4'b0000;
         step();
         e = exp_v(0, 0, 0, 4'b0000, 4'b0000, 0, 0); n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL xz_pulse_end: got %b expected %b", obs(), e); end
      end
      req = 4'b0001;
      step();
      e = exp_v(1, 0, 0, 4'b0001, 4'b0000, 0, 0); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL xz_then_grant0: got %b expected %b", obs(), e); end
      drain();
      step();
   endtask

   task automatic test_timeout();
      req = 4'b0001;
      step();
      req = 4'b0000; grant_ready = 1'b1;
      step();
      grant_ready = 1'b0;
      for (int k = 1; k < TO; k++) begin
         step();
         e = exp_v(0, 1, 0, 4'b0001, 4'b0000, 0, 0); n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL timeout_hold[%0d]: got %b expected %b", k, obs(), e); end
      end
      step();
      e = exp_v(0, 0, 0, 4'b0000, 4'b0000, 0, 1); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL timeout_fire: got %b expected %b", obs(), e); end
      step();
      e = exp_v(0, 0, 0, 4'b0000, 4'b0000, 0, 0); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL timeout_pulse_end: got %b expected %b", obs(), e); end
      req = 4'b0001;
      step();
      req = 4'b0000; grant_ready = 1'b1;
      step();
      grant_ready = 1'b0;
      for (int k = 1; k < TO; k++) step();
      done = 1'b1;
      step();
      e = exp_v(0, 0, 0, 4'b0000, 4'b0000, 0, 0); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL done_beats_timeout: got %b expected %b", obs(), e); end
      done = 1'b0;
      step();
      n_checks++;
      if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL no_late_timeout: got %b expected 0", timeout_err); end
   endtask

   task automatic test_async_reset();
      req = 4'b0101;
      step();
      e = exp_v(1, 0, 2, 4'b0100, 4'b0001, 0, 0); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL ares_grant: got %b expected %b", obs(), e); end
      req = 4'b0100;
      step();
      e = exp_v(1, 0, 2, 4'b0100, 4'b0101, 0, 0); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL ares_pending: got %b expected %b", obs(), e); end
      req = 4'b0000;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs() !== 14'd0) begin n_fail++; $display("FAIL ares_immediate: got %b expected %b", obs(), 14'd0); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      n_checks++;
      if (obs() !== 14'd0) begin n_fail++; $display("FAIL ares_after_release: got %b expected %b", obs(), 14'd0); end
   endtask

   task automatic test_random();
      logic [3:0] m_pend, nxt, r;
      int m_phase, m_id, m_age, hi;
      logic m_err;
      do_reset();
      m_pend = 4'b0000; m_phase = 0; m_id = 0; m_age = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         req = r;
         grant_ready = 1'($urandom_range(0, 1));
         done = ($urandom_range(0, 5) == 0);
         nxt = m_pend | r;
         m_err = 1'b0;
         if (m_phase == 0) begin
            hi = -1;
            for (int b = 3; b >= 0; b--) if (hi < 0 && nxt[b]) hi = b;
            if (hi >= 0) begin
               m_id = hi; nxt[hi] = 1'b0; m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (grant_ready) begin m_phase = 2; m_age = 0; end
         end else begin
            if (done) m_phase = 0;
            else begin
               m_age++;
               if (m_age == TO) begin m_err = 1'b1; m_phase = 0; end
            end
         end
         m_pend = nxt;
         step();
         e = exp_v(m_phase == 1, m_phase == 2, 2'(m_id),
                   (m_phase != 0) ? (4'b0001 << m_id) : 4'b0000, m_pend, 1'b0, m_err);
         n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL random[%0d]: got %b expected %b", cyc, obs(), e); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_all_four();
      test_xz();
      test_timeout();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
